// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - fetch, data and shared-memory signal bundle for memory_arbiter
interface memory_arbiter_if;
    logic        IF_REQ;
    logic [31:0] IF_ADDR;
    logic [31:0] IF_RDATA;
    logic        IF_VALID;
    logic        IF_STALL;

    logic        D_RD;
    logic        D_WR;
    logic [31:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic [2:0]  D_SIZE;
    logic [31:0] D_RDATA;
    logic        D_VALID;
    logic        D_STALL;

    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [2:0]  MEM_SIZE;
    logic        MEM_WE;
    logic        MEM_RDEN;
    logic [31:0] MEM_RDATA;
    logic        MEM_ACK;

    modport slave (
        input  IF_REQ, IF_ADDR, D_RD, D_WR, D_ADDR, D_WDATA, D_SIZE, MEM_RDATA, MEM_ACK,
        output IF_RDATA, IF_VALID, IF_STALL, D_RDATA, D_VALID, D_STALL,
               MEM_ADDR, MEM_WDATA, MEM_SIZE, MEM_WE, MEM_RDEN
    );

    modport master (
        output IF_REQ, IF_ADDR, D_RD, D_WR, D_ADDR, D_WDATA, D_SIZE, MEM_RDATA, MEM_ACK,
        input  IF_RDATA, IF_VALID, IF_STALL, D_RDATA, D_VALID, D_STALL,
               MEM_ADDR, MEM_WDATA, MEM_SIZE, MEM_WE, MEM_RDEN
    );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - fetch/data arbiter onto one single-port memory with fetch anti-starvation
module memory_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic            ARB_CLOCK,
    input  logic            ARB_RESET,
    memory_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] starve_cnt;
    logic          d_req;
    logic          starve_full;
    logic          mem_done;
    logic          grant_if;
    logic          grant_d;

    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [2:0]    mem_size;
    logic          mem_we;
    logic          mem_rden;
    logic [31:0]   if_rdata;
    logic [31:0]   d_rdata;
    logic          if_valid;
    logic          d_valid;

    assign d_req       = bus.D_RD | bus.D_WR;
    assign starve_full = (starve_cnt == CW'(STARVE_MAX));
    assign mem_done    = bus.MEM_ACK & ((state == IF_BUSY) | (state == D_BUSY));

    always_ff @(posedge ARB_CLOCK) begin
        if (ARB_RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Data side wins in IDLE unless fetch has been passed over STARVE_MAX times in a row
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.IF_REQ && (!d_req || starve_full)) begin
                    grant_if  = 1'b1;
                    state_nxt = IF_BUSY;
                end else if (d_req) begin
                    grant_d   = 1'b1;
                    state_nxt = D_BUSY;
                end
            end
            IF_BUSY, D_BUSY: begin
                if (bus.MEM_ACK) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ARB_CLOCK) begin
        if (ARB_RESET) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_size  <= '0;
            mem_we    <= 1'b0;
            mem_rden  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if (grant_if) begin
                mem_addr <= bus.IF_ADDR;
                mem_size <= 3'b010;
                mem_we   <= 1'b0;
                mem_rden <= 1'b1;
            end else if (grant_d) begin
                mem_addr  <= bus.D_ADDR;
                mem_size  <= bus.D_SIZE;
                mem_wdata <= bus.D_WDATA;
                mem_we    <= bus.D_WR;
                mem_rden  <= bus.D_RD & ~bus.D_WR;
            end else if (mem_done) begin
                mem_we   <= 1'b0;
                mem_rden <= 1'b0;
                if (state == IF_BUSY) begin
                    if_valid <= 1'b1;
                    if_rdata <= bus.MEM_RDATA;
                end else begin
                    d_valid <= 1'b1;
                    // a write completion leaves the last load value in place
                    if (mem_rden) begin
                        d_rdata <= bus.MEM_RDATA;
                    end
                end
            end
        end
    end

    always_ff @(posedge ARB_CLOCK) begin
        if (ARB_RESET) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_if || !bus.IF_REQ) begin
                starve_cnt <= '0;
            end else if (grant_d && !starve_full) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign bus.MEM_ADDR  = mem_addr;
    assign bus.MEM_WDATA = mem_wdata;
    assign bus.MEM_SIZE  = mem_size;
    assign bus.MEM_WE    = mem_we;
    assign bus.MEM_RDEN  = mem_rden;
    assign bus.IF_RDATA  = if_rdata;
    assign bus.IF_VALID  = if_valid;
    assign bus.D_RDATA   = d_rdata;
    assign bus.D_VALID   = d_valid;
    assign bus.IF_STALL  = bus.IF_REQ & ~if_valid;
    assign bus.D_STALL   = d_req & ~d_valid;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter with memory responder and arbitration model
module tb_memory_arbiter;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_arbiter_if bus();

    memory_arbiter #(.STARVE_MAX(SMAX)) dut (
        .ARB_CLOCK (clk),
        .ARB_RESET (rst),
        .bus       (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem_model [logic [31:0]];
    bit          mem_auto  = 1'b1;
    int          lat_cfg   = 0;
    int          cur_lat   = 0;
    int          busy_cyc  = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : ((a * 32'h9E37_79B9) ^ 32'h5A5A_0000);
    endfunction

    // Memory side: ACK after lat_cfg waiting cycles (random 0..3 when negative), stray ACKs while idle
    task automatic mem_respond();
        if (!mem_auto) return;
        if (bus.MEM_RDEN === 1'b1 || bus.MEM_WE === 1'b1) begin
            if (busy_cyc == 0) cur_lat = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
            if (busy_cyc == cur_lat) begin
                bus.MEM_ACK   = 1'b1;
                bus.MEM_RDATA = mem_rd(bus.MEM_ADDR);
                if (bus.MEM_WE === 1'b1) mem_model[bus.MEM_ADDR] = bus.MEM_WDATA;
            end else begin
                bus.MEM_ACK   = 1'b0;
                bus.MEM_RDATA = $urandom;
            end
            busy_cyc++;
        end else begin
            busy_cyc      = 0;
            bus.MEM_ACK   = (lat_cfg < 0) && ($urandom_range(0, 3) == 0);
            bus.MEM_RDATA = $urandom;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_respond();
    endtask

    task automatic clear_inputs();
        bus.IF_REQ  = 1'b0; bus.IF_ADDR = '0;
        bus.D_RD    = 1'b0; bus.D_WR    = 1'b0;
        bus.D_ADDR  = '0;   bus.D_WDATA = '0; bus.D_SIZE = '0;
        bus.MEM_ACK = 1'b0; bus.MEM_RDATA = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear_inputs(); mem_auto = 1'b1; lat_cfg = 0;
        tick(); tick();
        vectors++;
        if ({bus.MEM_ADDR, bus.MEM_WDATA, bus.MEM_SIZE} !== 67'd0) begin
            miscompares++; $display("FAIL reset_mem_bus got %h want 0", {bus.MEM_ADDR, bus.MEM_WDATA, bus.MEM_SIZE});
        end
        vectors++;
        if ({bus.IF_RDATA, bus.D_RDATA} !== 64'd0) begin
            miscompares++; $display("FAIL reset_rdata got %h want 0", {bus.IF_RDATA, bus.D_RDATA});
        end
        vectors++;
        if ({bus.MEM_WE, bus.MEM_RDEN, bus.IF_VALID, bus.D_VALID, bus.IF_STALL, bus.D_STALL} !== 6'd0) begin
            miscompares++; $display("FAIL reset_flags got %b want 000000",
                {bus.MEM_WE, bus.MEM_RDEN, bus.IF_VALID, bus.D_VALID, bus.IF_STALL, bus.D_STALL});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_if_read();
        logic [31:0] exp2;
        lat_cfg = 0;
        mem_model[32'h100] = 32'h0000_0513;
        exp2 = mem_rd(32'h104);
        bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h100;
        tick();
        vectors++;
        if ({bus.MEM_RDEN, bus.MEM_WE, bus.MEM_SIZE, bus.MEM_ADDR} !== {1'b1, 1'b0, 3'b010, 32'h100}) begin
            miscompares++; $display("FAIL if_grant_bus got %h want %h",
                {bus.MEM_RDEN, bus.MEM_WE, bus.MEM_SIZE, bus.MEM_ADDR}, {1'b1, 1'b0, 3'b010, 32'h100});
        end
        vectors++;
        if ({bus.IF_STALL, bus.IF_VALID} !== 2'b10) begin
            miscompares++; $display("FAIL if_busy_stall got %b want 10", {bus.IF_STALL, bus.IF_VALID});
        end
        tick();
        vectors++;
        if ({bus.IF_VALID, bus.IF_STALL, bus.MEM_RDEN, bus.IF_RDATA} !== {3'b100, 32'h0000_0513}) begin
            miscompares++; $display("FAIL if_complete got %h want %h",
                {bus.IF_VALID, bus.IF_STALL, bus.MEM_RDEN, bus.IF_RDATA}, {3'b100, 32'h0000_0513});
        end
        bus.IF_ADDR = 32'h104;
        tick();
        vectors++;
        if ({bus.MEM_RDEN, bus.IF_VALID, bus.IF_STALL} !== 3'b001) begin
            miscompares++; $display("FAIL resp_no_grant got %b want 001", {bus.MEM_RDEN, bus.IF_VALID, bus.IF_STALL});
        end
        tick();
        vectors++;
        if ({bus.MEM_RDEN, bus.MEM_ADDR} !== {1'b1, 32'h104}) begin
            miscompares++; $display("FAIL if_regrant got %h want %h", {bus.MEM_RDEN, bus.MEM_ADDR}, {1'b1, 32'h104});
        end
        tick();
        vectors++;
        if ({bus.IF_VALID, bus.IF_RDATA} !== {1'b1, exp2}) begin
            miscompares++; $display("FAIL if_b2b_data got %h want %h", {bus.IF_VALID, bus.IF_RDATA}, {1'b1, exp2});
        end
        bus.IF_REQ = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        logic [31:0] exp_if;
        lat_cfg = 0;
        exp_if = mem_rd(32'h200);
        bus.IF_REQ = 1'b1; bus.IF_ADDR = 32'h200;
        bus.D_WR = 1'b1; bus.D_ADDR = 32'h0001_1000; bus.D_WDATA = 32'hDEAD_BEEF; bus.D_SIZE = 3'b010;
        tick();
        vectors++;
        if ({bus.MEM_WE, bus.MEM_RDEN, bus.MEM_SIZE, bus.MEM_ADDR, bus.MEM_WDATA} !==
            {1'b1, 1'b0, 3'b010, 32'h0001_1000, 32'hDEAD_BEEF}) begin
            miscompares++; $display("FAIL prio_write_first got %h want %h",
                {bus.MEM_WE, bus.MEM_RDEN, bus.MEM_SIZE, bus.MEM_ADDR, bus.MEM_WDATA},
                {1'b1, 1'b0, 3'b010, 32'h0001_1000, 32'hDEAD_BEEF});
        end
        tick();
        vectors++;
        if ({bus.D_VALID, bus.IF_VALID, bus.D_STALL, bus.IF_STALL} !== 4'b1001) begin
            miscompares++; $display("FAIL prio_d_valid got %b want 1001", {bus.D_VALID, bus.IF_VALID, bus.D_STALL, bus.IF_STALL});
        end
        bus.D_WR = 1'b0;
        tick();
        vectors++;
        if ({bus.MEM_WE, bus.MEM_RDEN} !== 2'b00) begin
            miscompares++; $display("FAIL prio_resp_idle got %b want 00", {bus.MEM_WE, bus.MEM_RDEN});
        end
        tick();
        vectors++;
        if ({bus.MEM_RDEN, bus.MEM_ADDR} !== {1'b1, 32'h200}) begin
            miscompares++; $display("FAIL prio_if_second got %h want %h", {bus.MEM_RDEN, bus.MEM_ADDR}, {1'b1, 32'h200});
        end
        tick();
        vectors++;
        if ({bus.IF_VALID, bus.IF_RDATA} !== {1'b1, exp_if}) begin
            miscompares++; $display("FAIL prio_if_data got %h want %h", {bus.IF_VALID, bus.IF_RDATA}, {1'b1, exp_if});
        end
        vectors++;
        if (mem_rd(32'h0001_1000) !== 32'hDEAD_BEEF) begin
            miscompares++; $display("FAIL prio_mem_written got %h want deadbeef", mem_rd(32'h0001_1000));
        end
        bus.IF_REQ = 1'b0;
        tick(); tick();
    endtask

    task automatic test_starve();
        logic [31:0] ia;
        int rounds = 0;
        int dg = 0;
        lat_cfg = -1;
        ia = 32'h300;
        bus.IF_REQ = 1'b1; bus.IF_ADDR = ia;
        bus.D_RD = 1'b1; bus.D_WR = 1'b0; bus.D_SIZE = 3'b010;
        bus.D_ADDR = 32'h400 + ($urandom_range(0, 31) << 2);
        for (int i = 0; i < 300 && rounds < 2; i++) begin
            tick();
            if (bus.D_VALID === 1'b1) begin
                dg++;
                bus.D_ADDR = 32'h400 + ($urandom_range(0, 31) << 2);
            end
            if (bus.IF_VALID === 1'b1) begin
                vectors++;
                if (dg != SMAX) begin
                    miscompares++; $display("FAIL starve_data_grants round %0d got %0d want %0d", rounds, dg, SMAX);
                end
                vectors++;
                if (bus.IF_RDATA !== mem_rd(ia)) begin
                    miscompares++; $display("FAIL starve_if_data got %h want %h", bus.IF_RDATA, mem_rd(ia));
                end
                rounds++; dg = 0; ia += 32'd4; bus.IF_ADDR = ia;
            end
        end
        vectors++;
        if (rounds != 2) begin
            miscompares++; $display("FAIL starve_rounds got %0d want 2", rounds);
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_rdwr_both();
        lat_cfg = 1;
        mem_model[32'h40] = 32'hCAFE_0040;
        mem_model[32'h44] = 32'h0BAD_0044;
        bus.D_RD = 1'b1; bus.D_ADDR = 32'h40; bus.D_SIZE = 3'b010;
        for (int i = 0; i < 20 && bus.D_VALID !== 1'b1; i++) tick();
        vectors++;
        if ({bus.D_VALID, bus.D_RDATA} !== {1'b1, 32'hCAFE_0040}) begin
            miscompares++; $display("FAIL both_preload_read got %h want %h", {bus.D_VALID, bus.D_RDATA}, {1'b1, 32'hCAFE_0040});
        end
        bus.D_RD = 1'b0;
        tick();
        bus.D_RD = 1'b1; bus.D_WR = 1'b1; bus.D_ADDR = 32'h44; bus.D_WDATA = 32'h1234_5678;
        tick();
        vectors++;
        if ({bus.MEM_WE, bus.MEM_RDEN} !== 2'b10) begin
            miscompares++; $display("FAIL both_as_write got %b want 10", {bus.MEM_WE, bus.MEM_RDEN});
        end
        for (int i = 0; i < 20 && bus.D_VALID !== 1'b1; i++) tick();
        vectors++;
        if ({bus.D_VALID, bus.D_RDATA} !== {1'b1, 32'hCAFE_0040}) begin
            miscompares++; $display("FAIL both_rdata_kept got %h want %h", {bus.D_VALID, bus.D_RDATA}, {1'b1, 32'hCAFE_0040});
        end
        vectors++;
        if (mem_rd(32'h44) !== 32'h1234_5678) begin
            miscompares++; $display("FAIL both_mem_written got %h want 12345678", mem_rd(32'h44));
        end
        clear_inputs();
        tick(); tick();
    endtask

    task automatic test_ack_delay();
        logic [31:0] a, w;
        int pulses;
        lat_cfg = 5;
        a = 32'h2000 + ($urandom_range(0, 255) << 2);
        w = $urandom;
        bus.D_WR = 1'b1; bus.D_ADDR = a; bus.D_WDATA = w; bus.D_SIZE = 3'b010;
        tick();
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if ({bus.MEM_WE, bus.MEM_RDEN, bus.MEM_ADDR, bus.MEM_WDATA, bus.D_STALL, bus.D_VALID} !==
                {1'b1, 1'b0, a, w, 1'b1, 1'b0}) begin
                miscompares++; $display("FAIL delay_hold cycle %0d got %h want %h", i,
                    {bus.MEM_WE, bus.MEM_RDEN, bus.MEM_ADDR, bus.MEM_WDATA, bus.D_STALL, bus.D_VALID},
                    {1'b1, 1'b0, a, w, 1'b1, 1'b0});
            end
            tick();
        end
        pulses = (bus.D_VALID === 1'b1) ? 1 : 0;
        vectors++;
        if (pulses != 1) begin
            miscompares++; $display("FAIL delay_valid_time got %0d want 1", pulses);
        end
        bus.D_WR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.D_VALID === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++; $display("FAIL delay_single_pulse got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        mem_auto = 1'b0;
        bus.MEM_ACK = 1'b0;
        bus.D_RD = 1'b1; bus.D_ADDR = 32'h80; bus.D_SIZE = 3'b010;
        tick();
        vectors++;
        if ({bus.MEM_RDEN, bus.MEM_ADDR} !== {1'b1, 32'h80}) begin
            miscompares++; $display("FAIL rmid_busy got %h want %h", {bus.MEM_RDEN, bus.MEM_ADDR}, {1'b1, 32'h80});
        end
        tick(); tick();
        rst = 1'b1; bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'hFFFF_EEEE;
        tick();
        vectors++;
        if ({bus.MEM_ADDR, bus.MEM_WDATA, bus.MEM_SIZE, bus.MEM_WE, bus.MEM_RDEN, bus.D_VALID, bus.D_RDATA} !== 102'd0) begin
            miscompares++; $display("FAIL rmid_reset_outputs got %h want 0",
                {bus.MEM_ADDR, bus.MEM_WDATA, bus.MEM_SIZE, bus.MEM_WE, bus.MEM_RDEN, bus.D_VALID, bus.D_RDATA});
        end
        rst = 1'b0; bus.D_RD = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({bus.D_VALID, bus.MEM_WE, bus.MEM_RDEN, bus.D_RDATA} !== 35'd0) begin
                miscompares++; $display("FAIL rmid_late_ack cycle %0d got %h want 0", i,
                    {bus.D_VALID, bus.MEM_WE, bus.MEM_RDEN, bus.D_RDATA});
            end
        end
        bus.MEM_ACK = 1'b0;
        mem_auto = 1'b1;
    endtask

    task automatic test_random();
        bit          if_pend = 0, d_pend = 0, drd = 0, dwr = 0;
        bit          active, prev_active = 0, ack_prev = 0, exp_if, exp_ifv, exp_dv;
        int          starve = 0, owner = 0;
        logic [31:0] ia = '0, da = '0, dw = '0;
        logic [2:0]  ds = '0;
        logic [31:0] g_addr = '0, g_wdata = '0, m_if_rdata = '0, m_d_rdata = '0, exp_if_data = '0, exp_d_next = '0;
        logic [2:0]  g_size = '0;
        bit          g_we = 0, g_rden = 0;
        int          kind;

        rst = 1'b1; clear_inputs(); lat_cfg = -1;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            active = (bus.MEM_RDEN === 1'b1) || (bus.MEM_WE === 1'b1);
            if (active && !prev_active) begin
                vectors++;
                if (!(if_pend || d_pend)) begin
                    miscompares++; $display("FAIL rnd_spurious_grant cycle %0d got grant want none", cyc);
                end
                exp_if = if_pend && (!d_pend || starve == SMAX);
                if (exp_if) begin
                    g_we = 0; g_rden = 1; g_size = 3'b010; g_addr = ia;
                    exp_if_data = mem_rd(ia);
                    owner = 1; starve = 0;
                end else begin
                    g_we = dwr; g_rden = drd && !dwr; g_size = ds; g_addr = da; g_wdata = dw;
                    exp_d_next = dwr ? m_d_rdata : mem_rd(da);
                    owner = 2;
                    starve = if_pend ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
                end
            end
            if (active) begin
                vectors++;
                if ({bus.MEM_WE, bus.MEM_RDEN, bus.MEM_SIZE, bus.MEM_ADDR, bus.MEM_WDATA} !==
                    {g_we, g_rden, g_size, g_addr, g_wdata}) begin
                    miscompares++; $display("FAIL rnd_mem_bus cycle %0d got %h want %h", cyc,
                        {bus.MEM_WE, bus.MEM_RDEN, bus.MEM_SIZE, bus.MEM_ADDR, bus.MEM_WDATA},
                        {g_we, g_rden, g_size, g_addr, g_wdata});
                end
            end
            exp_ifv = ack_prev && owner == 1;
            exp_dv  = ack_prev && owner == 2;
            vectors++;
            if ({bus.IF_VALID, bus.D_VALID, bus.IF_STALL, bus.D_STALL} !==
                {exp_ifv, exp_dv, if_pend && !exp_ifv, d_pend && !exp_dv}) begin
                miscompares++; $display("FAIL rnd_valid_stall cycle %0d got %b want %b", cyc,
                    {bus.IF_VALID, bus.D_VALID, bus.IF_STALL, bus.D_STALL},
                    {exp_ifv, exp_dv, if_pend && !exp_ifv, d_pend && !exp_dv});
            end
            if (exp_ifv) begin m_if_rdata = exp_if_data; if_pend = 0; owner = 0; end
            if (exp_dv)  begin m_d_rdata  = exp_d_next;  d_pend  = 0; owner = 0; end
            vectors++;
            if ({bus.IF_RDATA, bus.D_RDATA} !== {m_if_rdata, m_d_rdata}) begin
                miscompares++; $display("FAIL rnd_rdata cycle %0d got %h want %h", cyc,
                    {bus.IF_RDATA, bus.D_RDATA}, {m_if_rdata, m_d_rdata});
            end
            ack_prev    = (bus.MEM_ACK === 1'b1) && active;
            prev_active = active;
            if (!if_pend && $urandom_range(0, 3) == 0) begin
                if_pend = 1; ia = 32'h100 + ($urandom_range(0, 15) << 2);
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; kind = $urandom_range(0, 3);
                drd = (kind != 2); dwr = (kind >= 2);
                da = 32'h100 + ($urandom_range(0, 15) << 2);
                dw = $urandom; ds = 3'($urandom_range(0, 7));
            end
            bus.IF_REQ = if_pend; bus.IF_ADDR = ia;
            bus.D_RD = d_pend && drd; bus.D_WR = d_pend && dwr;
            bus.D_ADDR = da; bus.D_WDATA = dw; bus.D_SIZE = ds;
        end
        clear_inputs();
        tick(); tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_if_read();
        test_priority();
        test_starve();
        test_rdwr_both();
        test_ack_delay();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
